// File: rtl/date_set_if.sv
// Button, running-date and load bus between the date setter and its neighbours.
// The master drives buttons and the running date; the slave returns the load/edit view.
interface date_set_if #(
  parameter int DW = 7
);
  logic          set_btn;
  logic          inc_btn;
  logic          dec_btn;
  logic          cancel;
  logic [DW-1:0] cur_month;
  logic [DW-1:0] cur_day;
  logic          ld;
  logic [DW-1:0] ld_month;
  logic [DW-1:0] ld_day;
  logic          setting;
  logic          sel_day;

  modport master (
    output set_btn, inc_btn, dec_btn, cancel, cur_month, cur_day,
    input  ld, ld_month, ld_day, setting, sel_day
  );

  modport slave (
    input  set_btn, inc_btn, dec_btn, cancel, cur_month, cur_day,
    output ld, ld_month, ld_day, setting, sel_day
  );
endinterface

// File: rtl/date_set_ctrl.sv
// Operator date editor: captures the running month/day, edits them with
// set/inc/dec button edges, keeps the day inside the month and issues a one-cycle load.
module date_set_ctrl #(
  parameter int DW      = 7,
  parameter int TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        rst,
  date_set_if.slave   bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MONTH  = 2'd1,
    S_DAY    = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] month_q, month_d;
  logic [DW-1:0] day_q, day_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          set_q, inc_q, dec_q;
  logic          ld_q, ld_d;
  logic          setting_q, setting_d;
  logic          sel_day_q, sel_day_d;

  logic          set_e_s, inc_e_s, dec_e_s;
  logic          inc_only_s, dec_only_s;
  logic [DW-1:0] last_s;

  // Last valid 0-based day of month m (Feb 28, Apr/Jun/Sep/Nov 30, others 31).
  function automatic logic [DW-1:0] last_day(input logic [DW-1:0] m);
    case (m)
      DW'(1):                          last_day = DW'(27);
      DW'(3), DW'(5), DW'(8), DW'(10): last_day = DW'(29);
      default:                         last_day = DW'(30);
    endcase
  endfunction

  assign set_e_s    = bus.set_btn & ~set_q;
  assign inc_e_s    = bus.inc_btn & ~inc_q;
  assign dec_e_s    = bus.dec_btn & ~dec_q;
  assign inc_only_s = inc_e_s & ~dec_e_s;
  assign dec_only_s = dec_e_s & ~inc_e_s;
  assign last_s     = last_day(month_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      month_q   <= '0;
      day_q     <= '0;
      cnt_q     <= '0;
      set_q     <= 1'b0;
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
      ld_q      <= 1'b0;
      setting_q <= 1'b0;
      sel_day_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      month_q   <= month_d;
      day_q     <= day_d;
      cnt_q     <= cnt_d;
      set_q     <= bus.set_btn;
      inc_q     <= bus.inc_btn;
      dec_q     <= bus.dec_btn;
      ld_q      <= ld_d;
      setting_q <= setting_d;
      sel_day_q <= sel_day_d;
    end
  end

  always_comb begin
    state_d = state_q;
    month_d = month_q;
    day_d   = day_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (set_e_s) begin
          month_d = bus.cur_month;
          day_d   = (bus.cur_day > last_day(bus.cur_month)) ? last_day(bus.cur_month)
                                                             : bus.cur_day;
          state_d = S_MONTH;
        end
      end
      S_MONTH, S_DAY: begin
        // Priority: cancel, then set (advance), then inc/dec, then idle timeout.
        if (bus.cancel) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (set_e_s) begin
          state_d = (state_q == S_MONTH) ? S_DAY : S_COMMIT;
          cnt_d   = '0;
        end else if (inc_e_s || dec_e_s) begin
          cnt_d = '0;
          if (state_q == S_MONTH) begin
            if (inc_only_s) begin
              month_d = (month_q == DW'(11)) ? DW'(0) : month_q + DW'(1);
            end else if (dec_only_s) begin
              month_d = (month_q == DW'(0)) ? DW'(11) : month_q - DW'(1);
            end else begin
              month_d = month_q;
            end
            if (day_q > last_day(month_d)) begin
              day_d = last_day(month_d);
            end else begin
              day_d = day_q;
            end
          end else begin
            if (inc_only_s) begin
              day_d = (day_q == last_s) ? DW'(0) : day_q + DW'(1);
            end else if (dec_only_s) begin
              day_d = (day_q == DW'(0)) ? last_s : day_q - DW'(1);
            end else begin
              day_d = day_q;
            end
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    ld_d      = (state_d == S_COMMIT);
    setting_d = (state_d != S_IDLE);
    sel_day_d = (state_d == S_DAY);
  end

  assign bus.ld       = ld_q;
  assign bus.ld_month = month_q;
  assign bus.ld_day   = day_q;
  assign bus.setting  = setting_q;
  assign bus.sel_day  = sel_day_q;
endmodule

// File: tb/tb_date_set_ctrl.sv
// Self-checking bench for date_set_ctrl: directed scenarios then random button
// traffic, all compared against a calendar-level reference model.
module tb_date_set_ctrl;
  localparam int DW = 7;
  localparam int TO = 40;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  date_set_if #(.DW(DW)) bus ();

  date_set_ctrl #(.DW(DW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: editing mode (0 idle, 1 month, 2 day, 3 load), date, idle timer.
  int m_mode, m_mon, m_day, m_tmr;
  int p_set, p_inc, p_dec;
  int cm, cd;

  function automatic int mlen(input int m);
    if (m == 1) return 28;
    if (m == 3 || m == 5 || m == 8 || m == 10) return 30;
    return 31;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_mon = 0; m_day = 0; m_tmr = 0;
    p_set = 0; p_inc = 0; p_dec = 0;
  endtask

  task automatic model_step(input int s, input int i, input int d, input int c);
    bit se, ie, de;
    se = s && !p_set; ie = i && !p_inc; de = d && !p_dec;
    p_set = s; p_inc = i; p_dec = d;
    if (m_mode == 0) begin
      if (se) begin
        m_mon  = cm;
        m_day  = (cd < mlen(cm)) ? cd : mlen(cm) - 1;
        m_mode = 1;
        m_tmr  = 0;
      end
    end else if (m_mode == 3) begin
      m_mode = 0;
    end else if (c) begin
      m_mode = 0;
    end else if (se) begin
      m_mode = m_mode + 1;
      m_tmr  = 0;
    end else if (ie || de) begin
      m_tmr = 0;
      if (ie != de) begin
        if (m_mode == 1) begin
          m_mon = ie ? (m_mon + 1) % 12 : (m_mon + 11) % 12;
          if (m_day >= mlen(m_mon)) m_day = mlen(m_mon) - 1;
        end else begin
          m_day = ie ? (m_day + 1) % mlen(m_mon) : (m_day + mlen(m_mon) - 1) % mlen(m_mon);
        end
      end
    end else if (m_tmr == TO - 1) begin
      m_mode = 0;
    end else begin
      m_tmr++;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".ld"},      int'(bus.ld),       (m_mode == 3) ? 1 : 0);
    check({tag, ".setting"}, int'(bus.setting),  (m_mode != 0) ? 1 : 0);
    check({tag, ".sel_day"}, int'(bus.sel_day),  (m_mode == 2) ? 1 : 0);
    check({tag, ".month"},   int'(bus.ld_month), m_mon);
    check({tag, ".day"},     int'(bus.ld_day),   m_day);
  endtask

  task automatic cyc(input string tag, input int s, input int i, input int d, input int c);
    @(negedge clk);
    bus.set_btn   = s[0];
    bus.inc_btn   = i[0];
    bus.dec_btn   = d[0];
    bus.cancel    = c[0];
    bus.cur_month = DW'(cm);
    bus.cur_day   = DW'(cd);
    @(posedge clk);
    model_step(s, i, d, c);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    bus.set_btn = 1'b0; bus.inc_btn = 1'b0; bus.dec_btn = 1'b0; bus.cancel = 1'b0;
    model_reset();
    @(negedge clk);
    compare_all(tag);
    rst = 1'b0;
  endtask

  // Press set once (rise then release): moves one step through the edit flow.
  task automatic press_set(input string tag);
    cyc(tag, 1, 0, 0, 0);
    cyc(tag, 0, 0, 0, 0);
  endtask

  int ld_seen;
  int rs, ri, rd, rc;

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b0;
    bus.set_btn = 1'b0; bus.inc_btn = 1'b0; bus.dec_btn = 1'b0; bus.cancel = 1'b0;
    cm = 0; cd = 0;
    bus.cur_month = '0; bus.cur_day = '0;
    do_reset("reset");

    // 1: capture and load unchanged date
    cm = 4; cd = 10;
    press_set("t1a");
    press_set("t1b");
    cyc("t1c", 1, 0, 0, 0);
    check("t1_ld", int'(bus.ld), 1);
    check("t1_month", int'(bus.ld_month), 4);
    check("t1_day", int'(bus.ld_day), 10);
    cyc("t1d", 0, 0, 0, 0);
    check("t1_idle_ld", int'(bus.ld), 0);
    check("t1_idle_setting", int'(bus.setting), 0);

    // 2: Jan 31 -> Feb clamps to 28th
    cm = 0; cd = 30;
    press_set("t2a");
    cyc("t2b", 0, 1, 0, 0);
    check("t2_clamp_day", int'(bus.ld_day), 27);
    cyc("t2c", 0, 0, 0, 0);
    press_set("t2d");
    cyc("t2e", 1, 0, 0, 0);
    check("t2_ld_day", int'(bus.ld_day), 27);
    cyc("t2f", 0, 0, 0, 0);

    // 3: month and day wrap boundaries
    cm = 11; cd = 5;
    press_set("t3a");
    cyc("t3b", 0, 1, 0, 0);
    check("t3_m_wrap_up", int'(bus.ld_month), 0);
    cyc("t3c", 0, 0, 1, 0);
    check("t3_m_wrap_dn", int'(bus.ld_month), 11);
    cyc("t3d", 0, 0, 0, 1);
    cm = 3; cd = 29;
    press_set("t3e");
    press_set("t3f");
    cyc("t3g", 0, 1, 0, 0);
    check("t3_d_wrap_up", int'(bus.ld_day), 0);
    cyc("t3h", 0, 0, 1, 0);
    check("t3_d_wrap_dn", int'(bus.ld_day), 29);

    // 4: held inc gives one step; simultaneous inc+dec no change
    cyc("t4a", 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) cyc("t4hold", 0, 1, 0, 0);
    check("t4_one_inc", int'(bus.ld_day), 0);
    cyc("t4b", 0, 0, 0, 0);
    cyc("t4both", 0, 1, 1, 0);
    check("t4_both", int'(bus.ld_day), 0);
    cyc("t4c", 0, 0, 0, 1);

    // 5: timeout in SET_DAY and cancel, never loading
    cm = 6; cd = 15;
    press_set("t5a");
    press_set("t5b");
    ld_seen = 0;
    for (int k = 0; k < TO + 2; k++) begin
      cyc("t5wait", 0, 0, 0, 0);
      if (bus.ld) ld_seen++;
    end
    check("t5_timeout_setting", int'(bus.setting), 0);
    check("t5_no_ld", ld_seen, 0);
    press_set("t5c");
    cyc("t5cancel", 0, 0, 0, 1);
    check("t5_cancel_setting", int'(bus.setting), 0);
    cyc("t5d", 1, 0, 0, 1);
    cyc("t5e", 0, 0, 0, 0);

    // 6: reset during COMMIT
    do_reset("t6pre");
    cm = 9; cd = 20;
    press_set("t6a");
    press_set("t6b");
    cyc("t6c", 1, 0, 0, 0);
    check("t6_commit_ld", int'(bus.ld), 1);
    rst = 1'b1;
    #1;
    model_reset();
    check("t6_rst_ld", int'(bus.ld), 0);
    compare_all("t6rst");
    bus.set_btn = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Random button traffic against the model
    rs = 0; ri = 0; rd = 0; rc = 0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 5) == 0) rs = !rs;
      if ($urandom_range(0, 3) == 0) ri = !ri;
      if ($urandom_range(0, 3) == 0) rd = !rd;
      rc = ($urandom_range(0, 59) == 0) ? 1 : 0;
      if ($urandom_range(0, 15) == 0) begin
        cm = $urandom_range(0, 11);
        cd = $urandom_range(0, 30);
      end
      if (k > 2000 && k < 2400) begin
        ri = 0; rd = 0; rc = 0;
      end
      cyc("rand", rs, ri, rd, rc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
